// File: rtl/pipe_stage_skid_pkg.sv
// Shared definitions for the valid/ready pipeline stage register.
// Holds the canonical NOP, control bit positions and stage state encoding.
package pipe_stage_skid_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0020;

    localparam int MEMREAD  = 0;
    localparam int MEMWRITE = 1;
    localparam int MEMTOREG = 2;
    localparam int REGWRITE = 3;
    localparam int REGDST   = 4;
    localparam int LINK     = 5;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } stage_state_t;

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear wins over increment; the count sticks at all-ones.
module pipe_stage_skid_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && !(&q)) begin
            q <= q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake and optional 2-entry skid.
// Empty or flushed slots present a NOP; stall and bubble cycles are counted.
module pipe_stage_skid #(
    parameter int          CTRL_W   = 6,
    parameter int          DATA_W   = 82,
    parameter logic [31:0] NOP_INST = pipe_stage_skid_pkg::NOP_INST,
    parameter bit          SKID_EN  = 1'b1,
    parameter int          CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              hold,
    input  logic              up_valid,
    output logic              up_ready,
    input  logic [CTRL_W-1:0] up_ctrl,
    input  logic [DATA_W-1:0] up_data,
    output logic              dn_valid,
    input  logic              dn_ready,
    output logic [CTRL_W-1:0] dn_ctrl,
    output logic [DATA_W-1:0] dn_data,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    import pipe_stage_skid_pkg::*;

    localparam logic [DATA_W-1:0] NOP_DATA = DATA_W'(NOP_INST);

    stage_state_t state, state_n;

    logic [CTRL_W-1:0] m_ctrl, s_ctrl;
    logic [DATA_W-1:0] m_data, s_data;

    logic rdy_eff, up_fire, dn_fire;
    logic m_load, m_from_s, s_load;

    assign rdy_eff  = dn_ready & ~hold;
    assign dn_valid = (state != EMPTY);
    assign up_ready = SKID_EN ? (state != TWO)
                              : ((state == EMPTY) | rdy_eff);
    assign up_fire  = up_valid & up_ready;
    assign dn_fire  = dn_valid & rdy_eff;

    assign dn_ctrl = dn_valid ? m_ctrl : '0;
    assign dn_data = dn_valid ? m_data : NOP_DATA;

    always_comb begin
        state_n  = state;
        m_load   = 1'b0;
        m_from_s = 1'b0;
        s_load   = 1'b0;
        if (flush) begin
            state_n = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (up_fire) begin
                        m_load  = 1'b1;
                        state_n = ONE;
                    end
                end
                ONE: begin
                    if (up_fire && dn_fire) begin
                        m_load = 1'b1;
                    end else if (up_fire && SKID_EN) begin
                        s_load  = 1'b1;
                        state_n = TWO;
                    end else if (dn_fire) begin
                        state_n = EMPTY;
                    end
                end
                TWO: begin
                    if (dn_fire) begin
                        m_from_s = 1'b1;
                        state_n  = ONE;
                    end
                end
                default: state_n = EMPTY;
            endcase
        end
    end

    // Flush overwrites both entries so stale payloads can never resurface.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= EMPTY;
            m_ctrl <= '0;
            m_data <= NOP_DATA;
            s_ctrl <= '0;
            s_data <= NOP_DATA;
        end else begin
            state <= state_n;
            if (flush) begin
                m_ctrl <= '0;
                m_data <= NOP_DATA;
                s_ctrl <= '0;
                s_data <= NOP_DATA;
            end else begin
                if (m_load) begin
                    m_ctrl <= up_ctrl;
                    m_data <= up_data;
                end else if (m_from_s) begin
                    m_ctrl <= s_ctrl;
                    m_data <= s_data;
                end
                if (s_load) begin
                    s_ctrl <= up_ctrl;
                    s_data <= up_data;
                end
            end
        end
    end

    pipe_stage_skid_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (dn_valid & ~rdy_eff),
        .clr   (cnt_clr),
        .q     (stall_cnt)
    );

    pipe_stage_skid_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (~dn_valid),
        .clr   (cnt_clr),
        .q     (bubble_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid (SKID_EN=1, CNT_W=4).
// Accepted payloads are queued and compared when the stage delivers them.
module tb_pipe_stage_skid;

    localparam int CTRL_W = 6;
    localparam int DATA_W = 82;
    localparam int CNT_W  = 4;
    localparam int PW     = CTRL_W + DATA_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush, hold;
    logic              up_valid, up_ready;
    logic [CTRL_W-1:0] up_ctrl;
    logic [DATA_W-1:0] up_data;
    logic              dn_valid, dn_ready;
    logic [CTRL_W-1:0] dn_ctrl;
    logic [DATA_W-1:0] dn_data;
    logic              cnt_clr;
    logic [CNT_W-1:0]  stall_cnt, bubble_cnt;

    int n_chk  = 0;
    int n_pass = 0;
    int n_rx   = 0;
    logic [PW-1:0] q[$];

    pipe_stage_skid #(
        .CTRL_W   (CTRL_W),
        .DATA_W   (DATA_W),
        .NOP_INST (32'h0000_0020),
        .SKID_EN  (1'b1),
        .CNT_W    (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .hold       (hold),
        .up_valid   (up_valid),
        .up_ready   (up_ready),
        .up_ctrl    (up_ctrl),
        .up_data    (up_data),
        .dn_valid   (dn_valid),
        .dn_ready   (dn_ready),
        .dn_ctrl    (dn_ctrl),
        .dn_data    (dn_data),
        .cnt_clr    (cnt_clr),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [95:0] got,
                       input logic [95:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic offer(input logic [CTRL_W-1:0] c, input logic [31:0] d);
        up_valid = 1'b1;
        up_ctrl  = c;
        up_data  = {50'(d), d};
    endtask

    // Called at a negedge with inputs set; scores this cycle's handshakes.
    task automatic step();
        #1;
        if (dn_valid && dn_ready && !hold) begin
            n_rx++;
            if (q.size() == 0) chk("sb_unexpected", {dn_ctrl, dn_data}, '1);
            else chk("sb_payload", {dn_ctrl, dn_data}, q.pop_front());
        end
        if (flush) q.delete();
        else if (up_valid && up_ready) q.push_back({up_ctrl, up_data});
        @(negedge clk);
    endtask

    task automatic drain();
        up_valid = 1'b0;
        dn_ready = 1'b1;
        hold     = 1'b0;
        for (int k = 0; k < 20 && q.size() > 0; k++) step();
        chk("drain_left", q.size(), 0);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; hold = 1'b0; cnt_clr = 1'b0;
        up_valid = 1'b0; up_ctrl = '0; up_data = '0; dn_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_dn_valid", dn_valid, 0);
        chk("rst_up_ready", up_ready, 1);
        chk("rst_nop", dn_data, 96'h20);
        chk("rst_bubble", bubble_cnt, 0);
        rst_n = 1'b1;

        // first load
        dn_ready = 1'b1;
        step();
        chk("t1_bubble_inc", bubble_cnt, 1);
        offer(6'h2B, 32'h8C22_0004);
        #1 chk("t1_pre_nop", dn_data[31:0], 32'h0000_0020);
        step();
        up_valid = 1'b0;
        chk("t1_bubble_load", bubble_cnt, 2);
        chk("t1_valid", dn_valid, 1);
        chk("t1_ctrl", dn_ctrl, 6'h2B);
        chk("t1_data", dn_data[31:0], 32'h8C22_0004);
        drain();

        // streaming
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        n_rx = 0;
        for (int i = 1; i <= 8; i++) begin
            offer(CTRL_W'(i), 32'(i));
            #1 chk("t2_up_ready", up_ready, 1);
            step();
        end
        up_valid = 1'b0;
        step();
        chk("t2_rx_count", n_rx, 8);
        chk("t2_stall", stall_cnt, 0);
        drain();

        // skid fill and release
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        dn_ready = 1'b0;
        offer(6'h0A, 32'hAAAA_0001);
        step();
        offer(6'h0B, 32'hBBBB_0002);
        step();
        offer(6'h0C, 32'hCCCC_0003);
        #1 chk("t3_up_ready", up_ready, 0);
        chk("t3_m_is_a", dn_data[31:0], 32'hAAAA_0001);
        step();
        dn_ready = 1'b1;
        step();
        step();
        up_valid = 1'b0;
        step();
        chk("t3_stall", stall_cnt, 2);
        chk("t3_empty", dn_valid, 0);
        drain();

        // flush in TWO
        dn_ready = 1'b0;
        offer(6'h11, 32'hDDDD_0004);
        step();
        offer(6'h12, 32'hEEEE_0005);
        step();
        offer(6'h13, 32'hFFFF_0006);
        flush = 1'b1;
        step();
        flush = 1'b0;
        up_valid = 1'b0;
        chk("t4_valid", dn_valid, 0);
        chk("t4_ctrl", dn_ctrl, 0);
        chk("t4_nop", dn_data[31:0], 32'h0000_0020);
        chk("t4_up_ready", up_ready, 1);
        dn_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t4_no_replay", dn_valid, 0);
        end

        // hold stall and clear priority
        hold = 1'b1;
        cnt_clr = 1'b1;
        offer(6'h21, 32'h1234_5678);
        step();
        cnt_clr = 1'b0;
        up_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t5_stable", dn_data[31:0], 32'h1234_5678);
        end
        chk("t5_stall", stall_cnt, 5);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        chk("t5_clr_wins", stall_cnt, 0);
        drain();

        // bubble saturation then async reset in TWO
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        for (int k = 0; k < 20; k++) step();
        chk("t6_sat", bubble_cnt, 4'hF);
        dn_ready = 1'b0;
        offer(6'h31, 32'h0000_0031);
        step();
        offer(6'h32, 32'h0000_0032);
        step();
        up_valid = 1'b0;
        chk("t6_in_two", up_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", dn_valid, 0);
        chk("t6_rst_ready", up_ready, 1);
        chk("t6_rst_ctrl", dn_ctrl, 0);
        chk("t6_rst_nop", dn_data, 96'h20);
        chk("t6_rst_stall", stall_cnt, 0);
        chk("t6_rst_bubble", bubble_cnt, 0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
Parametrised pipeline stage register for the 5-stage MIPS core; the next generation of the fixed IF/ID, ID/EX, EX/MEM and MEM/WB latches.
- Replaces the stall/flush latch with a valid/ready handshake.
- A 2-entry skid buffer registers the upstream ready, so backpressure does not ripple combinationally through the pipe.
- Flushed or empty slots present a canonical NOP.
- Built-in saturating stall and bubble counters support performance debug.

Parameters:
CTRL_W, 6, width of control bundle (memread, memwrite, memtoreg, regwrite, regdst, link, ...); zeroed when slot invalid
DATA_W, 82, width of data payload; bits [31:0] carry the instruction word; must be >= 32
NOP_INST, 32'h0000_0020, instruction word presented in data[31:0] when the slot is invalid
SKID_EN, 1, 1 = 2-entry skid with registered up_ready; 0 = single entry with combinational up_ready
CNT_W, 16, width of the performance counters

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
flush  in  1  synchronous kill of all held entries
hold  in  1  external stall; forces effective downstream ready to 0
up_valid  in  1  upstream payload valid
up_ready  out  1  stage can accept a payload this cycle
up_ctrl  in  CTRL_W  upstream control bundle
up_data  in  DATA_W  upstream data payload
dn_valid  out  1  output slot valid
dn_ready  in  1  downstream accepts
dn_ctrl  out  CTRL_W  control bundle; 0 when dn_valid=0
dn_data  out  DATA_W  payload; {0, NOP_INST} when dn_valid=0
cnt_clr  in  1  synchronous clear of both counters
stall_cnt  out  CNT_W  cycles with dn_valid=1 and rdy_eff=0
bubble_cnt  out  CNT_W  cycles with dn_valid=0

Behaviour:
Definitions:
- rdy_eff = dn_ready & ~hold
- up_fire = up_valid & up_ready
- dn_fire = dn_valid & rdy_eff

Storage and state:
- Main entry M drives the outputs; skid entry S exists only when SKID_EN=1.
- FSM state is EMPTY, ONE or TWO. TWO is unreachable when SKID_EN=0.

Outputs:
- dn_valid = (state != EMPTY).
- dn_ctrl/dn_data = M payload when valid; otherwise 0 / {0, NOP_INST}.
- SKID_EN=1: up_ready = (state != TWO), a function of registered state only.
- SKID_EN=0: up_ready = (state == EMPTY) | rdy_eff.

Reset (async):
- state=EMPTY; M and S payloads = {ctrl 0, data {0, NOP_INST}}.
- Counters = 0. Hence dn_valid=0 and up_ready=1 during reset.

Transitions (flush absent):
- EMPTY: up_fire -> M <= up, go to ONE.
- ONE, up_fire & dn_fire -> M <= up, stay in ONE.
- ONE, up_fire only -> S <= up, go to TWO. With SKID_EN=0 this case cannot occur.
- ONE, dn_fire only -> EMPTY.
- ONE, neither -> hold M.
- TWO: up_ready=0. dn_fire -> M <= S, go to ONE; otherwise hold.

Flush:
- Highest priority over every handshake.
- Next state = EMPTY; M and S are overwritten with the NOP payload.
- An up_fire in the flush cycle is discarded.
- A dn_fire in the flush cycle still counts as consumed downstream; no replay.

Timing:
- Latency is 1 cycle from up_fire to dn_valid when the stage is empty.
- Sustained throughput is 1 per cycle while rdy_eff=1.
- Payload order is preserved; no payload is duplicated or dropped except by flush.

Counters:
- Counters saturate at all-ones; no wrap.
- cnt_clr takes priority over an increment in the same cycle (result 0).
- Counters are unaffected by flush. The cycles in EMPTY that follow a flush count as bubbles.

Decomposition:
- Shared package holds:
  - NOP_INST constant (32'h0000_0020)
  - ctrl bit-index localparams (MEMREAD..LINK)
  - stage-state enum {EMPTY, ONE, TWO}
- One natural sub-module: sat_counter (CNT_W, inc, clr), instantiated twice.
- The payload registers are kept inline.

Test Plan:
1. Reset release, then up_valid=1 with up_ctrl=6'h2B, up_data[31:0]=32'h8C22_0004, dn_ready=1 -> next cycle dn_valid=1, dn_ctrl=6'h2B, dn_data[31:0]=32'h8C22_0004; before the load dn_data[31:0]=32'h0000_0020 and bubble_cnt increments.
2. Streaming 8 payloads 1..8 with dn_ready=1 -> received in order 1..8 on consecutive cycles; up_ready stays 1; stall_cnt=0.
3. SKID_EN=1: dn_ready=0 while 3 payloads A,B,C are offered -> A in M, B in S, up_ready=0 and C held. Then dn_ready=1 -> A, B, C delivered; stall_cnt equals the number of hold cycles.
4. flush while in TWO with up_valid=1 -> next cycle dn_valid=0, dn_ctrl=0, dn_data[31:0]=32'h0000_0020, up_ready=1; none of the flushed or offered payloads ever appear.
5. hold=1 with dn_ready=1 and M valid for 5 cycles -> dn_data stable; stall_cnt increases by 5; asserting cnt_clr in the same cycle as an increment reads 0.
6. CNT_W=4 with a permanent empty pipe for 20 cycles -> bubble_cnt saturates at 4'hF; rst_n dropped mid-stream in TWO -> all outputs at reset values immediately (async).
